// File: rtl/mem_wb_if.sv
// mem_wb_if: M-stage entry inputs and W-stage register-file write/status outputs.
interface mem_wb_if #(parameter int CNT_W = 32);
    logic             en;
    logic             flush;
    logic             m_valid;
    logic [31:0]      m_pc;
    logic             m_we;
    logic [4:0]       m_rd;
    logic [1:0]       m_wsel;
    logic [2:0]       m_ld_type;
    logic [1:0]       m_addr_lo;
    logic [31:0]      m_alu;
    logic [31:0]      m_dm;
    logic             w_we;
    logic [4:0]       w_a3;
    logic [31:0]      w_wd;
    logic [31:0]      w_pc;
    logic             w_valid;
    logic             align_err;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output en, flush, m_valid, m_pc, m_we, m_rd, m_wsel, m_ld_type, m_addr_lo, m_alu, m_dm,
        input  w_we, w_a3, w_wd, w_pc, w_valid, align_err, retire_cnt
    );
    modport slave (
        input  en, flush, m_valid, m_pc, m_we, m_rd, m_wsel, m_ld_type, m_addr_lo, m_alu, m_dm,
        output w_we, w_a3, w_wd, w_pc, w_valid, align_err, retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extension, misalign detection and retire counting.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input logic     clk,
    input logic     clr_n,
    mem_wb_if.slave bus
);
    logic             valid_q, valid_d, we_q, we_d, fresh_q, fresh_d, align_err_q, align_err_d;
    logic [31:0]      pc_q, pc_d, alu_q, alu_d, dm_q, dm_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       wsel_q, wsel_d, addr_lo_q, addr_lo_d;
    logic [2:0]       ld_type_q, ld_type_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             retire, misalign, is_lw, is_half;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      load_v;

    always_comb begin
        fresh_d      = bus.en & ~bus.flush;
        valid_d      = bus.flush ? 1'b0  : bus.en ? bus.m_valid   : valid_q;
        pc_d         = bus.flush ? '0    : bus.en ? bus.m_pc      : pc_q;
        we_d         = bus.flush ? 1'b0  : bus.en ? bus.m_we      : we_q;
        rd_d         = bus.flush ? '0    : bus.en ? bus.m_rd      : rd_q;
        wsel_d       = bus.flush ? '0    : bus.en ? bus.m_wsel    : wsel_q;
        ld_type_d    = bus.flush ? '0    : bus.en ? bus.m_ld_type : ld_type_q;
        addr_lo_d    = bus.flush ? '0    : bus.en ? bus.m_addr_lo : addr_lo_q;
        alu_d        = bus.flush ? '0    : bus.en ? bus.m_alu     : alu_q;
        dm_d         = bus.flush ? '0    : bus.en ? bus.m_dm      : dm_q;
        // Encodings 101-111 fall back to word loads.
        is_lw        = ld_type_q == 3'b000 || ld_type_q > 3'b100;
        is_half      = ld_type_q == 3'b011 || ld_type_q == 3'b100;
        misalign     = wsel_q == 2'b01 &&
                       ((is_lw && addr_lo_q != 2'b00) || (is_half && addr_lo_q[0]));
        retire       = valid_q & fresh_q;
        byte_v       = addr_lo_q[1] ? (addr_lo_q[0] ? dm_q[31:24] : dm_q[23:16])
                                    : (addr_lo_q[0] ? dm_q[15:8]  : dm_q[7:0]);
        half_v       = addr_lo_q[1] ? dm_q[31:16] : dm_q[15:0];
        load_v       = ld_type_q == 3'b001 ? {24'b0, byte_v} :
                       ld_type_q == 3'b010 ? {{24{byte_v[7]}}, byte_v} :
                       ld_type_q == 3'b011 ? {16'b0, half_v} :
                       ld_type_q == 3'b100 ? {{16{half_v[15]}}, half_v} : dm_q;
        align_err_d  = align_err_q | (retire & misalign);
        retire_cnt_d = retire_cnt_q + CNT_W'(retire);
    end

    assign bus.w_we       = retire & we_q & (rd_q != 5'd0) & ~misalign & (wsel_q != 2'b11);
    assign bus.w_a3       = rd_q;
    assign bus.w_pc       = pc_q;
    assign bus.w_valid    = valid_q;
    assign bus.align_err  = align_err_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.w_wd       = wsel_q == 2'b00 ? alu_q :
                            wsel_q == 2'b01 ? load_v :
                            wsel_q == 2'b10 ? pc_q + 32'd8 : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            we_q         <= 1'b0;
            rd_q         <= '0;
            wsel_q       <= '0;
            ld_type_q    <= '0;
            addr_lo_q    <= '0;
            alu_q        <= '0;
            dm_q         <= '0;
            fresh_q      <= 1'b0;
            align_err_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            wsel_q       <= wsel_d;
            ld_type_q    <= ld_type_d;
            addr_lo_q    <= addr_lo_d;
            alu_q        <= alu_d;
            dm_q         <= dm_d;
            fresh_q      <= fresh_d;
            align_err_q  <= align_err_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of retire counter.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 clr_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  1 = load next M-stage entry; 0 = hold W entry.
REQ-005 flush  in  1  synchronous bubble insert; priority over en.
REQ-006 m_valid  in  1  M-stage entry holds a real instruction.
REQ-007 m_pc  in  32  PC of M-stage instruction.
REQ-008 m_we  in  1  instruction writes the register file.
REQ-009 m_rd  in  5  destination register number.
REQ-010 m_wsel  in  2  write source: 00 ALU, 01 memory, 10 PC+8, 11 reserved.
REQ-011 m_ld_type  in  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, 101-111 treated as lw.
REQ-012 m_addr_lo  in  2  data address bits [1:0].
REQ-013 m_alu  in  32  ALU result; m_dm  in  32  raw data-memory word.
REQ-014 w_we / w_a3[5] / w_wd[32] / w_pc[32]  out  register-file write port (also forwarding source).
REQ-015 w_valid  out  1  W entry holds a real instruction.
REQ-016 align_err  out  1  sticky misaligned-load flag.
REQ-017 retire_cnt  out  CNT_W  instructions retired since reset.

Function
REQ-018 Latency one cycle: on rising edge with en=1, flush=0, all m_* fields are captured into W registers; outputs are combinational from W registers.
REQ-019 flush=1 at an edge loads a bubble: valid=0, we=0, rd=0, pc=0, wsel=00, data fields 0, irrespective of en.
REQ-020 en=0, flush=0 holds all W registers unchanged.
REQ-021 A "fresh" bit is set on every capture (en=1, flush=0) and cleared on any edge without capture; write and retire happen only while fresh=1.
REQ-022 Misalign when wsel=01 and: lw with addr_lo!=00; lh/lhu with addr_lo[0]=1; bytes never misalign.
REQ-023 w_we = valid & fresh & we & (rd!=0) & !misalign & (wsel!=11).
REQ-024 w_wd: wsel 00 -> alu; 10 -> pc+8 (modulo 2^32); 11 -> 0; 01 -> load extension below.
REQ-025 Byte select: addr_lo 00 -> dm[7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24]; lbu zero-extends, lb sign-extends.
REQ-026 Halfword select: addr_lo[1]=0 -> dm[15:0], 1 -> dm[31:16]; lhu zero-extends, lh sign-extends.
REQ-027 w_a3 = rd, w_pc = pc, w_valid = valid, all unmasked by fresh.
REQ-028 align_err sets on edge where valid & fresh & misalign; cleared only by reset.
REQ-029 retire_cnt increments by 1 on each edge where valid & fresh (including suppressed writes and misaligned loads); wraps from all-ones to 0.
REQ-030 Flush and capture on same edge as a fresh W entry: current entry still retires (counter increments) on that edge.

Reset
REQ-031 clr_n=0 immediately forces all W registers, fresh, align_err and retire_cnt to 0; w_we=0, w_wd=0, w_pc=0, w_valid=0 while asserted.
REQ-032 Reset deassertion mid-stream: first capture occurs on first rising edge with clr_n=1 and en=1.

Verification
REQ-033 lw: m_wsel=01, ld_type=000, addr_lo=00, dm=0x12345678, rd=8, pc=0x3000 -> next cycle w_we=1, w_a3=8, w_wd=0x12345678, w_pc=0x3000; retire_cnt 0->1.
REQ-034 lb addr_lo=11, dm=0x80FF0000 -> w_wd=0xFFFFFF80; lhu addr_lo=10 same dm -> w_wd=0x000080FF; lh addr_lo=00, dm=0x00008001 -> 0xFFFF8001.
REQ-035 jal-style: wsel=10, pc=0x3010, rd=31 -> w_wd=0x3018; rd=0 variant -> w_we=0, retire_cnt still increments.
REQ-036 Stall: capture then en=0 for 3 cycles -> w_we=1 only first cycle, outputs stable, retire_cnt +1 total.
REQ-037 lw addr_lo=10 -> w_we=0, align_err=1 stays 1 through later good loads until clr_n=0; flush with en=1 -> next cycle w_valid=0, w_we=0.
REQ-038 clr_n pulsed low between edges with valid fresh entry -> outputs 0 at once, no retire counted, retire_cnt=0.
